// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption sequencer: owns the cipher state register and
// reuses one external round function plus one addRoundKey across 11 key applications.

module aes_add_round_key (
  input  logic [127:0] text_i,
  input  logic [127:0] key_i,
  output logic [127:0] text_o
);
  assign text_o = text_i ^ key_i;
endmodule

module aes_round_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] rf_state,
  output logic         rf_last,
  input  logic [127:0] rf_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] ark_text, ark_out;

  // The initial whitening and every round share one addRoundKey; only its text input is muxed.
  assign ark_text = (fsm_q == ROUND) ? rf_out : text_in;

  aes_add_round_key u_ark (
    .text_i (ark_text),
    .key_i  (rk_in),
    .text_o (ark_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    if (round_q > LAST_ROUND) begin
      fsm_d   = IDLE;
      round_d = '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid && key_ready) begin
            state_d = ark_out;
            round_d = 4'd1;
            fsm_d   = ROUND;
          end
        end
        ROUND: begin
          state_d = ark_out;
          if (round_q == LAST_ROUND) begin
            // Counter parks at 0 so 11..15 stay unreachable.
            round_d = '0;
            fsm_d   = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) fsm_d = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = key_ready && (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q != IDLE);
    rk_idx    = (fsm_q == ROUND) ? round_q : 4'd0;
    rf_last   = (fsm_q == ROUND) && (round_q == LAST_ROUND);
    rf_state  = state_q;
    text_out  = state_q;
  end

endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative AES-128 encryption sequencer that owns the 128-bit cipher state register and time-multiplexes a single combinational round function plus the existing addRoundKey datapath across the 11 round-key applications of one block. It sits between the key-expansion store, which supplies round keys by index, and the host stream interface, which provides plaintext and consumes ciphertext under valid/ready handshakes. One block is in flight at a time.

## Interface
- No parameters; fixed AES-128: 10 rounds, round keys 0..10.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- key_ready  input  1  round-key store holds a complete expanded key
- in_valid  input  1  text_in is valid
- in_ready  output  1  controller accepts a new block
- text_in  input  128  plaintext, AES byte order, byte 0 in bits [127:120]
- out_valid  output  1  text_out holds finished ciphertext
- out_ready  input  1  consumer accepts text_out
- text_out  output  128  ciphertext, driven from the state register
- rk_idx  output  4  round-key index requested, 0..10
- rk_in  input  128  round key for rk_idx, combinational, valid in the same cycle
- rf_state  output  128  state presented to the external round function
- rf_last  output  1  1 = final round: round function skips MixColumns
- rf_out  input  128  SubBytes/ShiftRows/[MixColumns] result, combinational
- busy  output  1  high in ROUND and DONE

## Operation
- State machine: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - rk_idx = 0; in_ready = key_ready.
  - On in_valid & in_ready: state <= text_in XOR rk_in, computed through the addRoundKey instance; round <= 1; go to ROUND.
- ROUND:
  - rk_idx = round; rf_state = state; rf_last = (round == 10).
  - Each cycle: state <= rf_out XOR rk_in, through the same addRoundKey instance via a 2:1 mux on its text_in; round <= round + 1.
  - After the round-10 update, go to DONE.
- DONE:
  - out_valid = 1; text_out = state, held stable until out_ready.
  - On out_ready: go to IDLE.
  - No new block is accepted in the handshake cycle; in_ready stays 0 outside IDLE.
- Round counter: 4 bits; values 11..15 are unreachable. If one is ever reached, force IDLE.
- key_ready is sampled only in IDLE. A drop of key_ready during ROUND or DONE is ignored; the key store must not change keys while busy.
- in_valid while not in_ready is ignored; text_in is not captured.
- out_ready while out_valid = 0 has no effect.

## Timing
- Reset values:
  - FSM = IDLE, round = 0, state = 0.
  - in_ready = key_ready (combinational).
  - out_valid = 0, busy = 0, rk_idx = 0, rf_last = 0, text_out = 0.
- Reset asserted mid-block aborts the block; the FSM is in IDLE in the cycle after the reset edge.
- Latency: accept edge E0, round edges E1..E10; out_valid is high in the cycle after E10, which is 10 cycles after acceptance.
- Minimum block period: 12 cycles (accept, 10 rounds, 1 DONE cycle with out_ready = 1).
- rk_idx, rf_state and rf_last are registered-state decodes with no combinational path from in_valid or out_ready.
- in_ready depends combinationally on key_ready only.

## Test plan
- FIPS-197 App. B, with a reference round-function model on rf_* and a key ROM for key 2b7e151628aed2a6abf7158809cf4f3c:
  - Inputs: text_in = 3243f6a8885a308d313198a2e0370734, out_ready = 1.
  - Required: state = 193de3bea0f4e22b9ac68d2ae9f84808 after E0.
  - Required: out_valid 10 cycles after accept, text_out = 3925841d02dc09fbdc118597196a0b32.
  - Required: rk_idx steps 0..10; rf_last is high only in the round-10 cycle.
- Backpressure: hold out_ready = 0 for 5 cycles after done.
  - Required: out_valid stays 1, text_out stays constant, in_ready = 0, in_valid pulses are ignored.
  - Required: on release, IDLE follows in the next cycle.
- key_ready = 0 with in_valid = 1 for 4 cycles.
  - Required: in_ready = 0 and no accept.
  - Required: raising key_ready causes acceptance in the same cycle.
- Reset mid-block: assert rst at round 5.
  - Required: next cycle busy = 0, out_valid = 0, in_ready = key_ready, rk_idx = 0.
  - Required: the next block completes with the correct ciphertext.
- Back-to-back: two blocks, App. B plaintext then 00112233445566778899aabbccddeeff under key 000102030405060708090a0b0c0d0e0f.
  - Required: outputs 3925841d... and 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: accepts are exactly 12 cycles apart with out_ready held at 1.
